// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer.
// State encoding, opcode field bounds and the sequential PC step.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    STOP  = 2'd3
  } fetch_state_t;

  localparam logic [5:0]  HALT_OPCODE_DEF = 6'b111111;
  localparam int          OPC_HI          = 31;
  localparam int          OPC_LO          = 26;
  localparam logic [31:0] PC_STEP         = 32'd4;

endpackage

// File: rtl/fetch_control_if.sv
// fetch_control_if: instruction-memory req/ack bus.
// master = fetch sequencer, slave = instruction memory.
interface fetch_control_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/next_pc_sel.sv
// next_pc_sel: next-PC priority mux with redirect alignment check.
// jr > jump > branch_taken > sequential pc + 4 (32-bit wrap).
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jr,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  output logic [31:0] prox_end,
  output logic        misaligned
);

  // Redirects may overlap, so this is a priority decode.
  always_comb begin
    prox_end   = pc + PC_STEP;
    misaligned = 1'b0;
    priority case (1'b1)
      jr: begin
        prox_end   = jr_target;
        misaligned = |jr_target[1:0];
      end
      jump: begin
        prox_end   = jump_target;
        misaligned = |jump_target[1:0];
      end
      branch_taken: begin
        prox_end   = branch_target;
        misaligned = |branch_target[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_control.sv
// fetch_control: fetch/exec sequencer driving the PC register.
// The PC register only loads prox_end when halt is low.
module fetch_control
  import fetch_pkg::*;
#(
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic               clock_pc,
  input  logic               reset,
  input  logic [31:0]        pc,
  fetch_control_if.master    imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  input  logic               stall_ext,
  input  logic               jr,
  input  logic               jump,
  input  logic               branch_taken,
  input  logic [31:0]        jr_target,
  input  logic [31:0]        jump_target,
  input  logic [31:0]        branch_target,
  output logic [31:0]        prox_end,
  output logic               halt,
  output logic               halted,
  output logic               fault
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [31:0] sel_pc;
  logic        misaligned;
  logic        in_exec;
  logic        is_halt;
  logic        advance;
  logic        bad_target;

  next_pc_sel u_next_pc_sel (
    .pc            (pc),
    .jr            (jr),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .jr_target     (jr_target),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .prox_end      (sel_pc),
    .misaligned    (misaligned)
  );

  assign in_exec    = (state_q == EXEC);
  assign is_halt    = (instr[OPC_HI:OPC_LO] == HALT_OPCODE);
  assign bad_target = in_exec && !is_halt && !stall_ext && misaligned;
  assign advance    = in_exec && !is_halt && !stall_ext && !misaligned;

  assign imem.imem_addr = pc;

  // State register; reset drops imem_req at once.
  always_ff @(posedge clock_pc or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: halt opcode beats stall, stall beats redirect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem.imem_ack) state_d = EXEC;
      EXEC: begin
        if (is_halt)         state_d = STOP;
        else if (stall_ext)  state_d = EXEC;
        else if (misaligned) state_d = STOP;
        else                 state_d = FETCH;
      end
      STOP:  state_d = STOP;
    endcase
  end

  // Outputs: PC is held everywhere except an advancing EXEC.
  always_comb begin
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    halt          = 1'b1;
    prox_end      = pc;
    unique case (state_q)
      IDLE:  prox_end = RESET_PC;
      FETCH: imem.imem_req = 1'b1;
      EXEC: begin
        instr_valid = 1'b1;
        prox_end    = sel_pc;
        halt        = !advance;
      end
      STOP:  ;
    endcase
  end

  // Instruction latch, loaded only on an ack seen in FETCH.
  always_ff @(posedge clock_pc or posedge reset) begin
    if (reset)
      instr <= 32'h0;
    else if (state_q == FETCH && imem.imem_ack)
      instr <= imem.imem_rdata;
  end

  // Sticky halt/fault flags, cleared only by reset.
  always_ff @(posedge clock_pc or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      if (in_exec && is_halt) halted <= 1'b1;
      if (bad_target)         fault  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// tb_fetch_control: directed bench for the fetch sequencer.
// Includes a PC register model that loads prox_end when halt is low.
module tb_fetch_control;

  logic        clock_pc = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall_ext;
  logic        jr, jump, branch_taken;
  logic [31:0] jr_target, jump_target, branch_target;
  logic [31:0] prox_end;
  logic        halt, halted, fault;
  logic        pc_set;
  logic [31:0] pc_set_val;

  int n_cmp = 0;
  int n_err = 0;

  fetch_control_if imem_bus ();

  fetch_control dut (
    .clock_pc      (clock_pc),
    .reset         (reset),
    .pc            (pc),
    .imem          (imem_bus),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .stall_ext     (stall_ext),
    .jr            (jr),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .jr_target     (jr_target),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .prox_end      (prox_end),
    .halt          (halt),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clock_pc = ~clock_pc;

  always @(posedge clock_pc or posedge reset) begin
    if (reset)       pc <= 32'h0;
    else if (pc_set) pc <= pc_set_val;
    else if (!halt)  pc <= prox_end;
  end

  typedef struct {
    logic        jr;
    logic        jump;
    logic        br;
    logic [31:0] jt;
    logic [31:0] jpt;
    logic [31:0] bt;
    logic        stall;
    logic [31:0] exp_pe;
    logic        exp_halt;
  } vec_t;

  vec_t vecs [7];

  task automatic chk32(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_pc);
    #2;
  endtask

  task automatic clear_redirect();
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jr_target = 32'h0; jump_target = 32'h0; branch_target = 32'h0;
  endtask

  task automatic check_reset(input string tag);
    chk1 ({tag, ".req"},    imem_bus.imem_req, 1'b0);
    chk32({tag, ".instr"},  instr,             32'h0);
    chk1 ({tag, ".valid"},  instr_valid,       1'b0);
    chk1 ({tag, ".halt"},   halt,              1'b1);
    chk1 ({tag, ".halted"}, halted,            1'b0);
    chk1 ({tag, ".fault"},  fault,             1'b0);
    chk32({tag, ".prox"},   prox_end,          32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    pc_set = 1'b0;
    pc_set_val = 32'h0;
    stall_ext = 1'b0;
    clear_redirect();
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'h0;

    //         jr  jmp br  jr_t       jmp_t      br_t       stl exp_pe     halt
    vecs[0] = '{1, 1, 1, 32'h100, 32'h200, 32'h300, 0, 32'h100, 0};
    vecs[1] = '{0, 1, 1, 32'h100, 32'h200, 32'h300, 0, 32'h200, 0};
    vecs[2] = '{0, 0, 1, 32'h100, 32'h200, 32'h300, 0, 32'h300, 0};
    vecs[3] = '{0, 0, 0, 32'h100, 32'h200, 32'h300, 0, 32'h00c, 0};
    vecs[4] = '{1, 0, 1, 32'h100, 32'h200, 32'h300, 1, 32'h100, 1};
    vecs[5] = '{0, 1, 0, 32'h100, 32'h201, 32'h300, 0, 32'h201, 1};
    vecs[6] = '{0, 0, 0, 32'h100, 32'h200, 32'h300, 1, 32'h00c, 1};

    step();
    step();
    check_reset("rst0");

    // Ack tied high, nop stream from pc 0
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h0;
    reset = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk1 ($sformatf("seq%0d.req", k),   imem_bus.imem_req, (k % 2) == 0);
      chk1 ($sformatf("seq%0d.valid", k), instr_valid,       (k % 2) == 1);
      chk1 ($sformatf("seq%0d.halt", k),  halt,              (k % 2) == 0);
      chk32($sformatf("seq%0d.addr", k),  imem_bus.imem_addr, 32'(4 * (k / 2)));
      if (k < 4) step();
    end

    // Ack delayed: four FETCH cycles at addr 8
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'hDEADBEEF;
    for (int w = 0; w < 4; w++) begin
      if (w == 3) begin
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'h12345678;
      end
      #1;
      chk1 ($sformatf("wait%0d.req", w),  imem_bus.imem_req,  1'b1);
      chk32($sformatf("wait%0d.addr", w), imem_bus.imem_addr, 32'h8);
      if (w < 3) step();
    end
    step();
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'hDEADBEEF;
    #1;
    chk32("ack.instr", instr, 32'h12345678);
    chk1 ("ack.valid", instr_valid, 1'b1);
    chk32("ack.pc",    pc, 32'h8);
    stall_ext = 1'b1;

    // Redirect table applied inside a stalled EXEC at pc 8
    for (int v = 0; v < 7; v++) begin
      step();
      jr = vecs[v].jr;
      jump = vecs[v].jump;
      branch_taken = vecs[v].br;
      jr_target = vecs[v].jt;
      jump_target = vecs[v].jpt;
      branch_target = vecs[v].bt;
      stall_ext = vecs[v].stall;
      #1;
      chk32($sformatf("vec%0d.prox", v),  prox_end,    vecs[v].exp_pe);
      chk1 ($sformatf("vec%0d.halt", v),  halt,        vecs[v].exp_halt);
      chk1 ($sformatf("vec%0d.valid", v), instr_valid, 1'b1);
      #1;
      stall_ext = 1'b1;
      clear_redirect();
    end
    step();
    stall_ext = 1'b0;
    #1;
    chk32("rel.prox", prox_end, 32'hC);
    chk1 ("rel.halt", halt, 1'b0);
    step();
    chk32("rel.pc",  pc, 32'hC);
    chk1 ("rel.req", imem_bus.imem_req, 1'b1);
    chk1 ("rel.fault", fault, 1'b0);

    // Wrap at top of address space, then misaligned branch
    pc_set = 1'b1;
    pc_set_val = 32'hFFFFFFFC;
    step();
    pc_set = 1'b0;
    chk32("wrap.addr", imem_bus.imem_addr, 32'hFFFFFFFC);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h0;
    step();
    imem_bus.imem_ack = 1'b0;
    #1;
    chk32("wrap.prox", prox_end, 32'h0);
    chk1 ("wrap.halt", halt, 1'b0);
    branch_taken = 1'b1;
    branch_target = 32'h102;
    #1;
    chk32("mis.prox",  prox_end, 32'h102);
    chk1 ("mis.halt",  halt, 1'b1);
    chk1 ("mis.fault0", fault, 1'b0);
    step();
    clear_redirect();
    chk1 ("mis.fault", fault, 1'b1);
    chk1 ("mis.halt1", halt, 1'b1);
    chk1 ("mis.req",   imem_bus.imem_req, 1'b0);
    chk1 ("mis.valid", instr_valid, 1'b0);
    chk32("mis.pc",    pc, 32'hFFFFFFFC);
    imem_bus.imem_ack = 1'b1;
    step();
    step();
    chk1 ("stop.req",   imem_bus.imem_req, 1'b0);
    chk1 ("stop.fault", fault, 1'b1);
    chk32("stop.pc",    pc, 32'hFFFFFFFC);

    // Halt opcode with a simultaneous jr
    reset = 1'b1;
    #1;
    check_reset("rst1");
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hFC000000;
    step();
    reset = 1'b0;
    step();
    step();
    jr = 1'b1;
    jr_target = 32'h100;
    #1;
    chk32("hop.instr", instr, 32'hFC000000);
    chk1 ("hop.valid", instr_valid, 1'b1);
    chk1 ("hop.halt",  halt, 1'b1);
    step();
    clear_redirect();
    for (int h = 0; h < 3; h++) begin
      chk1 ($sformatf("hlt%0d.halted", h), halted, 1'b1);
      chk1 ($sformatf("hlt%0d.halt", h),   halt, 1'b1);
      chk1 ($sformatf("hlt%0d.req", h),    imem_bus.imem_req, 1'b0);
      chk32($sformatf("hlt%0d.pc", h),     pc, 32'h0);
      step();
    end

    // Five-cycle stall, then reset in the middle of FETCH
    reset = 1'b1;
    #1;
    reset = 1'b0;
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h00000020;
    stall_ext = 1'b1;
    step();
    step();
    for (int s = 0; s < 5; s++) begin
      chk1 ($sformatf("stl%0d.halt", s),  halt, 1'b1);
      chk1 ($sformatf("stl%0d.valid", s), instr_valid, 1'b1);
      chk32($sformatf("stl%0d.pc", s),    pc, 32'h0);
      if (s < 4) step();
    end
    stall_ext = 1'b0;
    imem_bus.imem_ack = 1'b0;
    #1;
    chk1 ("stl.rel", halt, 1'b0);
    step();
    chk1 ("midf.req",   imem_bus.imem_req, 1'b1);
    chk32("midf.addr",  imem_bus.imem_addr, 32'h4);
    chk32("midf.instr", instr, 32'h00000020);
    reset = 1'b1;
    #1;
    check_reset("rst2");
    imem_bus.imem_ack = 1'b1;
    step();
    chk32("rst2.instr_held", instr, 32'h0);
    reset = 1'b0;
    step();
    chk1 ("post.req",   imem_bus.imem_req, 1'b1);
    chk1 ("post.valid", instr_valid, 1'b0);
    chk32("post.addr",  imem_bus.imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
